ir_array_reader: RTL and testbench



---
 rtl/ir_array_reader.sv | 150 +++++++++++++++
 tb/tb_ir_array_reader.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/ir_array_reader.sv
`default_nettype none
// ============================================================================
// ir_array_reader : RC-discharge reflectance array reader (charge, time, latch)
// Rev 1.0
// ============================================================================
module ir_array_reader #(
    parameter int N_CH       = 4,
    parameter int CHARGE_CYC = 65,
    parameter int PERIOD_CYC = 32750,
    parameter int CNT_W      = 16,
    parameter int OUT_W      = 8,
    parameter int SHIFT      = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    inout  wire  [N_CH-1:0]       ir_io,
    input  logic [OUT_W-1:0]      threshold,
    output logic [N_CH*OUT_W-1:0] distancia,
    output logic [N_CH-1:0]       linea,
    output logic [N_CH-1:0]       timeout,
    output logic                  descarga,
    output logic                  valid
);

    localparam int M_CYC = PERIOD_CYC - CHARGE_CYC - 1;
    localparam int CYC_W = $clog2(PERIOD_CYC);
    localparam int WW    = (CNT_W > OUT_W) ? CNT_W : OUT_W;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [OUT_W-1:0] OUT_MAX = '1;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_CHARGE  = 2'd1;
    localparam logic [1:0] S_MEASURE = 2'd2;
    localparam logic [1:0] S_LATCH   = 2'd3;

    logic [1:0]                  state_q, state_d;
    logic [CYC_W-1:0]            cyc_q, cyc_d;
    logic [N_CH-1:0]             sync1_q, sync2_q;
    logic [N_CH-1:0][CNT_W-1:0]  cnt_q, cnt_d;
    logic [N_CH-1:0]             sat_q, sat_d;
    logic [N_CH*OUT_W-1:0]       dist_q, dist_d;
    logic [N_CH-1:0]             tout_q, tout_d;
    logic                        valid_q, valid_d;

    function automatic logic [OUT_W-1:0] scale(input logic [CNT_W-1:0] c);
        logic [WW-1:0] s;
        s = WW'(c) >> SHIFT;
        if (s > WW'(OUT_MAX))
            return OUT_MAX;
        return s[OUT_W-1:0];
    endfunction

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        cnt_d   = cnt_q;
        sat_d   = sat_q;
        dist_d  = dist_q;
        tout_d  = tout_q;
        valid_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    state_d = S_CHARGE;
                    cyc_d   = '0;
                end
            end
            S_CHARGE: begin
                if (cyc_q == CYC_W'(CHARGE_CYC - 1)) begin
                    state_d = S_MEASURE;
                    cyc_d   = '0;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            S_MEASURE: begin
                // The first two cycles still hold pre-release data in the synchroniser.
                if (cyc_q >= CYC_W'(2)) begin
                    for (int i = 0; i < N_CH; i++) begin
                        if (sync2_q[i] && (cnt_q[i] != CNT_MAX)) begin
                            cnt_d[i] = cnt_q[i] + 1'b1;
                            if (cnt_d[i] == CNT_MAX)
                                sat_d[i] = 1'b1;
                        end
                    end
                end
                if (cyc_q == CYC_W'(M_CYC - 1)) begin
                    state_d = S_LATCH;
                    cyc_d   = '0;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            S_LATCH: begin
                for (int i = 0; i < N_CH; i++)
                    dist_d[i*OUT_W +: OUT_W] = scale(cnt_q[i]);
                tout_d  = sat_q;
                cnt_d   = '0;
                sat_d   = '0;
                valid_d = 1'b1;
                cyc_d   = '0;
                state_d = enable ? S_CHARGE : S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cyc_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cyc_q   <= '0;
            sync1_q <= '0;
            sync2_q <= '0;
            cnt_q   <= '0;
            sat_q   <= '0;
            dist_q  <= '0;
            tout_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            sync1_q <= ir_io;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
            dist_q  <= dist_d;
            tout_q  <= tout_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        linea = '0;
        for (int i = 0; i < N_CH; i++)
            linea[i] = dist_q[i*OUT_W +: OUT_W] > threshold;
    end

    assign descarga  = (state_q == S_CHARGE);
    assign ir_io     = descarga ? {N_CH{1'b1}} : {N_CH{1'bz}};
    assign distancia = dist_q;
    assign timeout   = tout_q;
    assign valid     = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_ir_array_reader.sv
`default_nettype none
// ============================================================================
// tb_ir_array_reader : directed table-driven bench, RC sensor pads modelled here
// Rev 1.0
// ============================================================================
module tb_ir_array_reader;

    localparam int NC = 2;
    localparam int CC = 4;
    localparam int PC = 40;
    localparam int SH = 1;
    localparam int OW = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              enable;
    logic [OW-1:0]     threshold;
    wire  [NC-1:0]     pad_a;
    wire  [NC-1:0]     pad_b;
    logic [NC*OW-1:0]  dist_a, dist_b;
    logic [NC-1:0]     linea_a, linea_b, to_a, to_b;
    logic              desc_a, desc_b, valid_a, valid_b;

    int hold [NC];
    int since = 0;
    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    ir_array_reader #(.N_CH(NC), .CHARGE_CYC(CC), .PERIOD_CYC(PC), .CNT_W(16),
                      .OUT_W(OW), .SHIFT(SH)) u_dut_a (
        .clk(clk), .rst(rst), .enable(enable), .ir_io(pad_a), .threshold(threshold),
        .distancia(dist_a), .linea(linea_a), .timeout(to_a), .descarga(desc_a),
        .valid(valid_a));

    ir_array_reader #(.N_CH(NC), .CHARGE_CYC(CC), .PERIOD_CYC(PC), .CNT_W(5),
                      .OUT_W(OW), .SHIFT(SH)) u_dut_b (
        .clk(clk), .rst(rst), .enable(enable), .ir_io(pad_b), .threshold(threshold),
        .distancia(dist_b), .linea(linea_b), .timeout(to_b), .descarga(desc_b),
        .valid(valid_b));

    // Sensor model: pad stays high for hold[i] cycles after the charge ends.
    always @(posedge clk) since <= desc_a ? 0 : since + 1;

    for (genvar g = 0; g < NC; g++) begin : g_sens
        assign pad_a[g] = desc_a ? 1'bz : (since < hold[g]);
        assign pad_b[g] = desc_b ? 1'bz : (since < hold[g]);
    end

    typedef struct {
        int         h0, h1;
        logic [7:0] thr;
        logic [7:0] da0, da1;
        logic [1:0] toa, lna;
        logic [7:0] db0, db1;
        logic [1:0] tob;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!valid_a && n < 200);
        check("valid_arrives", 32'(valid_a), 32'd1);
    endtask

    vec_t vecs [5];
    int   n, nv, ndesc, last_v, gap_err, pad_err, dist_err, held_err;

    initial begin
        vecs[0] = '{h0:1000, h1:0,    thr:8'd0, da0:8'd16, da1:8'd0,  toa:2'b00, lna:2'b01,
                    db0:8'd15, db1:8'd0,  tob:2'b01};
        vecs[1] = '{h0:10,   h1:0,    thr:8'd4, da0:8'd5,  da1:8'd0,  toa:2'b00, lna:2'b01,
                    db0:8'd5,  db1:8'd0,  tob:2'b00};
        vecs[2] = '{h0:10,   h1:0,    thr:8'd5, da0:8'd5,  da1:8'd0,  toa:2'b00, lna:2'b00,
                    db0:8'd5,  db1:8'd0,  tob:2'b00};
        vecs[3] = '{h0:0,    h1:20,   thr:8'd9, da0:8'd0,  da1:8'd10, toa:2'b00, lna:2'b10,
                    db0:8'd0,  db1:8'd10, tob:2'b00};
        vecs[4] = '{h0:7,    h1:1000, thr:8'd3, da0:8'd3,  da1:8'd16, toa:2'b00, lna:2'b10,
                    db0:8'd3,  db1:8'd15, tob:2'b10};

        rst = 1'b1; enable = 1'b0; threshold = '0; hold[0] = 0; hold[1] = 0;
        repeat (3) @(negedge clk);
        check("rst_dist", 32'(dist_a), 32'd0);
        check("rst_timeout", 32'(to_a), 32'd0);
        check("rst_valid", 32'(valid_a), 32'd0);
        check("rst_descarga", 32'(desc_a), 32'd0);
        check("rst_pad", 32'(pad_a), 32'd0);
        @(negedge clk) rst = 1'b0;
        repeat (5) @(negedge clk);
        check("idle_no_charge", 32'(desc_a), 32'd0);

        // One frame per vector: a single-cycle enable pulse runs exactly one frame.
        for (int v = 0; v < 5; v++) begin
            threshold = vecs[v].thr;
            hold[0]   = vecs[v].h0;
            hold[1]   = vecs[v].h1;
            enable    = 1'b1;
            @(negedge clk) enable = 1'b0;
            wait_valid(n);
            check($sformatf("v%0d_latency", v), 32'(n), 32'd40);
            check($sformatf("v%0d_dist0", v), 32'(dist_a[7:0]), 32'(vecs[v].da0));
            check($sformatf("v%0d_dist1", v), 32'(dist_a[15:8]), 32'(vecs[v].da1));
            check($sformatf("v%0d_timeout", v), 32'(to_a), 32'(vecs[v].toa));
            check($sformatf("v%0d_linea", v), 32'(linea_a), 32'(vecs[v].lna));
            check($sformatf("v%0d_b_valid", v), 32'(valid_b), 32'd1);
            check($sformatf("v%0d_b_dist0", v), 32'(dist_b[7:0]), 32'(vecs[v].db0));
            check($sformatf("v%0d_b_dist1", v), 32'(dist_b[15:8]), 32'(vecs[v].db1));
            check($sformatf("v%0d_b_timeout", v), 32'(to_b), 32'(vecs[v].tob));
            repeat (3) @(negedge clk);
        end

        // Continuous run: frame spacing, charge length and pad drive.
        hold[0] = 1000; hold[1] = 0; threshold = '0;
        nv = 0; ndesc = 0; last_v = 0; gap_err = 0; pad_err = 0; dist_err = 0;
        enable = 1'b1;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (desc_a) begin
                ndesc++;
                if (pad_a != 2'b11) pad_err++;
            end else if (pad_a[1] != 1'b0) begin
                pad_err++;
            end
            if (valid_a) begin
                if (nv > 0 && i - last_v != 40) gap_err++;
                if (dist_a != {8'd0, 8'd16} || to_a != 2'b00) dist_err++;
                nv++;
                last_v = i;
            end
        end
        check("cont_valid_count", 32'(nv), 32'd4);
        check("cont_valid_gap_err", 32'(gap_err), 32'd0);
        check("cont_charge_cycles", 32'(ndesc), 32'd20);
        check("cont_pad_err", 32'(pad_err), 32'd0);
        check("cont_result_err", 32'(dist_err), 32'd0);
        enable = 1'b0;
        wait_valid(n);

        // Enable dropped in cycle 10: frame completes, then stays idle with results held.
        hold[0] = 10; hold[1] = 0;
        repeat (2) @(negedge clk);
        enable = 1'b1;
        repeat (10) @(negedge clk);
        enable = 1'b0;
        wait_valid(n);
        check("drop_latency", 32'(n + 10), 32'd41);
        check("drop_dist", 32'(dist_a), 32'({8'd0, 8'd5}));
        nv = 0; ndesc = 0; held_err = 0;
        repeat (60) begin
            @(negedge clk);
            if (valid_a) nv++;
            if (desc_a) ndesc++;
            if (dist_a != {8'd0, 8'd5}) held_err++;
        end
        check("drop_no_valid", 32'(nv), 32'd0);
        check("drop_no_charge", 32'(ndesc), 32'd0);
        check("drop_held_err", 32'(held_err), 32'd0);

        // Reset during MEASURE clears outputs asynchronously and discards partial counts.
        hold[0] = 1000; hold[1] = 1000;
        enable = 1'b1;
        repeat (20) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_rst_dist", 32'(dist_a), 32'd0);
        check("async_rst_timeout", 32'(to_a), 32'd0);
        check("async_rst_descarga", 32'(desc_a), 32'd0);
        check("async_rst_valid", 32'(valid_a), 32'd0);
        @(negedge clk) rst = 1'b0;
        wait_valid(n);
        check("post_rst_latency", 32'(n), 32'd41);
        check("post_rst_dist", 32'(dist_a), 32'({8'd16, 8'd16}));
        enable = 1'b0;
        wait_valid(n);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
